// File: rtl/ram_bist_pkg.sv
// RAM BIST shared definitions.
// State encoding, geometry and pattern constants.
package ram_bist_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam logic [3:0] PAT_HI = 4'hA;
  localparam int FLUSH_CYC = 2;
  localparam int ERR_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

endpackage

// File: rtl/ram_bist_checker.sv
// RAM BIST read checker.
// Two-stage expect pipeline, compare, error count, first-fail latch.
module ram_bist_checker #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_exp,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  logic              v0, v1;
  logic [ADDR_W-1:0] a0, a1;
  logic [DATA_W-1:0] e0, e1;
  logic              mism;

  assign mism = v1 && (mem_dout != e1);

  // Expected value and address follow the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      a0 <= '0;
      a1 <= '0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      v0 <= in_vld;
      a0 <= in_addr;
      e0 <= in_exp;
      v1 <= v0;
      a1 <= a0;
      e1 <= e0;
    end
  end

  // Saturating mismatch count; address of the first miss only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      fail_addr <= '0;
    end else if (clr) begin
      err_count <= '0;
      fail_addr <= '0;
    end else if (mism) begin
      if (err_count == '0)
        fail_addr <= a1;
      if (err_count != {ERR_W{1'b1}})
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: rtl/ram_bist_16x8.sv
// RAM BIST controller, 16x8 synchronous RAM.
// Two-phase write/read march with true and inverted data.
module ram_bist_16x8 #(
  parameter int ADDR_W = ram_bist_pkg::ADDR_W,
  parameter int DATA_W = ram_bist_pkg::DATA_W,
  parameter logic [DATA_W-ADDR_W-1:0] PAT_HI =
    ram_bist_pkg::PAT_HI
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  import ram_bist_pkg::*;

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic              ph_q, ph_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [FW-1:0]     f_q, f_d;
  logic              we_d, rd_d, busy_d, done_d, clr;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic [DATA_W-1:0] exp_d;

  function automatic logic [DATA_W-1:0] pat(
    input logic              p,
    input logic [ADDR_W-1:0] a
  );
    pat = p ? ~{PAT_HI, a} : {PAT_HI, a};
  endfunction

  // Next state, next address and next RAM command.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    a_d     = a_q;
    f_d     = f_q;
    we_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = '0;
    din_d   = '0;
    done_d  = done;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          ph_d    = 1'b0;
          a_d     = '0;
          done_d  = 1'b0;
          clr     = 1'b1;
          we_d    = 1'b1;
          din_d   = pat(1'b0, '0);
        end
      end
      S_WRITE: begin
        if (a_q == LAST) begin
          state_d = S_READ;
          a_d     = '0;
          rd_d    = 1'b1;
        end else begin
          a_d    = a_q + 1'b1;
          we_d   = 1'b1;
          addr_d = a_d;
          din_d  = pat(ph_q, a_d);
        end
      end
      S_READ: begin
        if (a_q == LAST) begin
          state_d = S_FLUSH;
          f_d     = '0;
        end else begin
          a_d    = a_q + 1'b1;
          rd_d   = 1'b1;
          addr_d = a_d;
        end
      end
      S_FLUSH: begin
        if (f_q == FW'(FLUSH_CYC - 1)) begin
          if (!ph_q) begin
            state_d = S_WRITE;
            ph_d    = 1'b1;
            a_d     = '0;
            we_d    = 1'b1;
            din_d   = pat(1'b1, '0);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          f_d = f_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_q != S_IDLE) &&
                  (state_q != S_DONE) &&
                  (state_d != S_DONE);

  assign exp_d = pat(ph_q, addr_d);

  // Control state and registered RAM/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ph_q     <= 1'b0;
      a_q      <= '0;
      f_q      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      a_q      <= a_d;
      f_q      <= f_d;
      mem_we   <= we_d;
      mem_addr <= addr_d;
      mem_din  <= din_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign pass = done && (err_count == '0);

  ram_bist_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .ERR_W (ERR_W)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_vld   (rd_d),
    .in_addr  (addr_d),
    .in_exp   (exp_d),
    .mem_dout (mem_dout),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );

endmodule

// File: tb/tb_ram_bist_16x8.sv
// Bench for ram_bist_16x8 with a faultable 16x8 RAM.
// Random fault runs checked against a pattern-level model.
module tb_ram_bist_16x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] fail_addr;

  logic [7:0] ram [16];
  logic [7:0] rd_q;
  logic [7:0] wr_val;
  logic [7:0] fmask;

  bit         fault_en;
  int         f_addr, f_bit;
  bit         f_val;
  bit         zero_mode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_bist_16x8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );

  // Stuck-at faults applied to the stored word.
  always_comb begin
    fmask  = 8'(1) << f_bit;
    wr_val = mem_din;
    if (fault_en && (int'(mem_addr) == f_addr))
      wr_val = f_val ? (mem_din | fmask) : (mem_din & ~fmask);
  end

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= wr_val;
    rd_q <= ram[mem_addr];
  end

  assign mem_dout = zero_mode ? 8'h00 : rd_q;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int pat_of(input int p, input int a);
    int t;
    t = 8'hA0 + a;
    return p ? (8'hFF - t) : t;
  endfunction

  function automatic int stored_of(input int p, input int a);
    int v;
    v = pat_of(p, a);
    if (fault_en && a == f_addr)
      v = f_val ? (v | (1 << f_bit)) : (v & ~(1 << f_bit));
    return v;
  endfunction

  // Expected outcome from the march rules.
  task automatic model(output int ec, output int fa);
    int seen, got;
    ec = 0;
    fa = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 16; a++) begin
        got = zero_mode ? 0 : stored_of(p, a);
        if (got != pat_of(p, a)) begin
          if (ec == 0) fa = a;
          ec++;
        end
      end
    seen = ec;
    if (seen > 31) ec = 31;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},   32'(mem_we),    0);
    chk({tag, "_addr"}, 32'(mem_addr),  0);
    chk({tag, "_din"},  32'(mem_din),   0);
    chk({tag, "_busy"}, 32'(busy),      0);
    chk({tag, "_done"}, 32'(done),      0);
    chk({tag, "_pass"}, 32'(pass),      0);
    chk({tag, "_err"},  32'(err_count), 0);
    chk({tag, "_fa"},   32'(fail_addr), 0);
  endtask

  task automatic run_test(input bit spur, input int rst_at);
    int ec, fa;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_err",  32'(err_count), 0);
    chk("clr_done", 32'(done), 0);
    for (int k = 1; k <= 68; k++) begin
      start = (spur && k == 10);
      @(posedge clk);
      #1;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_we",   32'(mem_we), 0);
        return;
      end
      if (k <= 67) chk("busy_run", 32'(busy), 1);
      if (k == 67) chk("done_early", 32'(done), 0);
    end
    start = 1'b0;
    model(ec, fa);
    chk("done_68",  32'(done), 1);
    chk("busy_end", 32'(busy), 0);
    chk("err_cnt",  32'(err_count), 32'(ec));
    chk("fail_adr", 32'(fail_addr), 32'(fa));
    chk("pass",     32'(pass), 32'(ec == 0));
    if (!fault_en && !zero_mode)
      for (int a = 0; a < 16; a++)
        chk("ram_data", 32'(ram[a]), 32'(pat_of(1, a)));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    fault_en  = 1'b0;
    f_addr    = 0;
    f_bit     = 0;
    f_val     = 1'b0;
    zero_mode = 1'b0;
    #1;
    check_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_hold", 32'(busy | done), 0);

    run_test(1'b1, 0);

    fault_en = 1'b1; f_addr = 5; f_bit = 0; f_val = 1'b0;
    run_test(1'b0, 0);

    fault_en = 1'b1; f_addr = 3; f_bit = 7; f_val = 1'b1;
    run_test(1'b0, 0);

    fault_en = 1'b0;
    run_test(1'b0, 0);

    zero_mode = 1'b1;
    run_test(1'b0, 0);
    zero_mode = 1'b0;

    run_test(1'b0, 20);
    run_test(1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      fault_en  = ($urandom_range(0, 3) != 0);
      f_addr    = $urandom_range(0, 15);
      f_bit     = $urandom_range(0, 7);
      f_val     = 1'($urandom_range(0, 1));
      zero_mode = ($urandom_range(0, 7) == 0);
      run_test(1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bist_16x8.md
RAM_BIST_16X8 -- requirements
Module: ram_bist_16x8

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width; the RAM depth is 2**ADDR_W = 16.
REQ-002 Parameter DATA_W, default 8, RAM word width.
REQ-003 Parameter PAT_HI, default 4'hA, upper nibble of the test pattern.
REQ-004 Port clk  input  1  single clock; every flop triggers on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  single-cycle request to run the test; sampled only in IDLE or DONE.
REQ-007 Port mem_we  output  1  write enable to the synchronous RAM.
REQ-008 Port mem_addr  output  ADDR_W  address to the RAM.
REQ-009 Port mem_din  output  DATA_W  write data to the RAM.
REQ-010 Port mem_dout  input  DATA_W  registered read data from the RAM, valid one edge after the address.
REQ-011 Port busy  output  1  high while the test runs.
REQ-012 Port done  output  1  test complete; sticky until restart or reset.
REQ-013 Port pass  output  1  high when done=1 and err_count=0.
REQ-014 Port err_count  output  5  count of mismatches; saturates at 31.
REQ-015 Port fail_addr  output  ADDR_W  address of the first mismatch; 0 if none.

Function
REQ-016 The block SHALL use the states IDLE, WRITE, READ, FLUSH and DONE, plus a phase bit ph (0 = true data, 1 = inverted data).
REQ-017 Pattern(a) SHALL be {PAT_HI, a} when ph=0 and ~{PAT_HI, a} when ph=1.
REQ-018 In IDLE or DONE, start=1 SHALL clear err_count, fail_addr, done and ph, and enter WRITE; start during the other states SHALL be ignored.
REQ-019 In WRITE, the block SHALL drive mem_we=1, mem_addr=a and mem_din=Pattern(a) for a=0..15 on 16 consecutive cycles.
REQ-020 When a=15 in WRITE, the next state SHALL be READ.
REQ-021 In READ, mem_we SHALL be 0 and mem_addr SHALL step through a=0..15 on 16 consecutive cycles.
REQ-022 When a=15 in READ, the next state SHALL be FLUSH.
REQ-023 FLUSH SHALL last 2 cycles with mem_we=0.
REQ-024 At the end of FLUSH, the block SHALL go to WRITE with ph=1 if ph was 0, otherwise to DONE.
REQ-025 An address launched on edge E SHALL be compared against mem_dout at edge E+2, using the expected value and address pipelined two stages.
REQ-026 A mismatch SHALL increment err_count, saturating at 31, and SHALL latch fail_addr only when err_count is 0.
REQ-027 done SHALL rise at the 68th rising edge after the edge that samples start; busy SHALL be 1 from the next edge through the 67th.
REQ-028 mem_we, mem_addr and mem_din SHALL be driven directly from flops.
REQ-029 mem_addr and mem_din SHALL be 0 outside WRITE and READ.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, ph=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, pass=0, err_count=0 and fail_addr=0, including mid-run.
REQ-031 After reset release, the block SHALL stay in IDLE until start=1.

Structure
REQ-032 Package ram_bist_pkg SHALL hold the state enum typedef and the constants ADDR_W, DATA_W, DEPTH=16, PAT_HI, FLUSH_CYC=2 and ERR_W=5.
REQ-033 Sub-module ram_bist_checker SHALL hold the two-stage expected-value/address pipeline, the comparator, the saturating err_count and the first-fail latch.
REQ-034 The RAM SHALL be outside the block; the top-level bench SHALL connect a 16x8 synchronous RAM model.

Verification
REQ-035 Fault-free RAM, start pulse -> done at edge 68, err_count=0, pass=1, fail_addr=0; the RAM holds 5F..50 at addresses 0..15.
REQ-036 Addr 5 bit0 stuck-at-0 -> phase 0 expects A5 and reads A4 -> err_count=1, fail_addr=5, pass=0.
REQ-037 Addr 3 bit7 stuck-at-1 -> phase 1 expects 5C and reads DC -> err_count=1, fail_addr=3.
REQ-038 mem_dout forced to 00 -> 32 mismatches -> err_count=31 (saturated), fail_addr=0.
REQ-039 rst_n low at edge 20 -> all outputs 0 immediately; a new start gives a normal run of 68 edges.
REQ-040 start pulsed at edge 10 while busy -> ignored and done still at edge 68; start in DONE -> counters cleared and the run repeats.
